// File: rtl/i2c_codec_pkg.sv
// Shared types and constants for the I2C codec register slave.
package i2c_codec_pkg;

  localparam int         NUM_REGS      = 16;
  localparam int         REG_W         = 9;
  localparam logic [6:0] SOFT_RST_ADDR = 7'h0F;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACK_ADDR,
    REG,
    ACK_REG,
    DATA,
    ACK_DATA,
    IGNORE
  } state_t;

endpackage

// File: rtl/i2c_codec_slave_if.sv
// Synchronized I2C bus events passed from the bus front end to the protocol FSM.
interface i2c_codec_slave_if;

  logic scl_rise;
  logic scl_fall;
  logic sda_s;
  logic start;
  logic stop;

  modport master (output scl_rise, scl_fall, sda_s, start, stop);
  modport slave  (input  scl_rise, scl_fall, sda_s, start, stop);

endinterface

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronizers on SCL/SDA plus edge, START and STOP detection.
// Events are valid three CLOCK_50 cycles after the bus pins change.
module i2c_bus_sync (
  input  logic              CLOCK_50,
  input  logic              iRST_N,
  input  logic              I2C_SCLK,
  input  logic              sdaIn,
  i2c_codec_slave_if.master bus
);

  logic [1:0] sclSync;
  logic [1:0] sdaSync;
  logic       sclDly;
  logic       sdaDly;
  logic [2:0] warm;
  logic       live;

  always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      sclSync <= 2'b11;
      sdaSync <= 2'b11;
      sclDly  <= 1'b1;
      sdaDly  <= 1'b1;
      warm    <= 3'b000;
    end else begin
      sclSync <= {sclSync[0], I2C_SCLK};
      sdaSync <= {sdaSync[0], sdaIn};
      sclDly  <= sclSync[1];
      sdaDly  <= sdaSync[1];
      warm    <= {warm[1:0], 1'b1};
    end
  end

  // Hold off events until the pipeline holds real bus samples, so a reset
  // released with SDA low cannot fake a START.
  assign live = warm[2];

  assign bus.sda_s    = sdaSync[1];
  assign bus.scl_rise = live &  sclSync[1] & ~sclDly;
  assign bus.scl_fall = live & ~sclSync[1] &  sclDly;
  assign bus.start    = live &  sclSync[1] & sclDly &  sdaDly & ~sdaSync[1];
  assign bus.stop     = live &  sclSync[1] & sclDly & ~sdaDly &  sdaSync[1];

endmodule

// File: rtl/i2c_codec_slave.sv
// Write-only I2C slave: {addr,W}, {reg[6:0],d[8]}, d[7:0] commits to a 16 x 9-bit file.
// Optional I2C_SLAVE_RESET_REG_EN: writing 9'h000 to register 0x0F clears every register.
module i2c_codec_slave
  import i2c_codec_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h1A
) (
  input  logic             CLOCK_50,
  input  logic             iRST_N,
  input  logic             I2C_SCLK,
  inout  wire              I2C_SDAT,
  input  logic [3:0]       RD_ADDR,
  output logic [REG_W-1:0] RD_DATA,
  output logic             WR_STROBE,
  output logic [6:0]       WR_ADDR,
  output logic [REG_W-1:0] WR_DATA,
  output logic             ACTIVE,
  output logic [7:0]       TXN_CNT
);

  i2c_codec_slave_if evIf ();

  i2c_bus_sync uSync (
    .CLOCK_50 (CLOCK_50),
    .iRST_N   (iRST_N),
    .I2C_SCLK (I2C_SCLK),
    .sdaIn    (I2C_SDAT),
    .bus      (evIf.master)
  );

  state_t           state, stateNxt;
  logic [3:0]       bitCnt;
  logic [7:0]       shiftReg;
  logic [6:0]       regAddr;
  logic             dataHi;
  logic             dataDone;
  logic             sdaOe, sdaOeNxt;
  logic             shiftEn, clrCnt, capReg, commit;
  logic [REG_W-1:0] commitData;
  logic [REG_W-1:0] regs [NUM_REGS];

  assign I2C_SDAT   = sdaOe ? 1'b0 : 1'bz;
  assign commitData = {dataHi, shiftReg};
  assign ACTIVE     = regs[9][0];

  always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      state <= IDLE;
      sdaOe <= 1'b0;
    end else begin
      state <= stateNxt;
      sdaOe <= sdaOeNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    sdaOeNxt = sdaOe;
    shiftEn  = 1'b0;
    clrCnt   = 1'b0;
    capReg   = 1'b0;
    commit   = 1'b0;
    if (evIf.stop) begin
      stateNxt = IDLE;
      sdaOeNxt = 1'b0;
    end else if (evIf.start) begin
      stateNxt = ADDR;
      sdaOeNxt = 1'b0;
      clrCnt   = 1'b1;
    end else begin
      unique case (state)
        ADDR, REG, DATA: begin
          if (evIf.scl_rise && bitCnt != 4'd8) shiftEn = 1'b1;
          // The falling edge after bit 8 opens the ACK slot.
          if (evIf.scl_fall && bitCnt == 4'd8) begin
            clrCnt = 1'b1;
            if (state == ADDR) begin
              if (shiftReg == {SLAVE_ADDR, 1'b0}) begin
                stateNxt = ACK_ADDR;
                sdaOeNxt = 1'b1;
              end else begin
                stateNxt = IGNORE;
              end
            end else if (state == REG) begin
              capReg   = 1'b1;
              stateNxt = ACK_REG;
              sdaOeNxt = 1'b1;
            end else if (dataDone) begin
              stateNxt = IGNORE;
            end else begin
              commit   = 1'b1;
              stateNxt = ACK_DATA;
              sdaOeNxt = 1'b1;
            end
          end
        end
        ACK_ADDR, ACK_REG, ACK_DATA: begin
          if (evIf.scl_fall) begin
            sdaOeNxt = 1'b0;
            stateNxt = (state == ACK_ADDR) ? REG : DATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      bitCnt   <= '0;
      shiftReg <= '0;
      regAddr  <= '0;
      dataHi   <= 1'b0;
      dataDone <= 1'b0;
    end else begin
      if (clrCnt)       bitCnt <= '0;
      else if (shiftEn) bitCnt <= bitCnt + 4'd1;
      if (shiftEn) shiftReg <= {shiftReg[6:0], evIf.sda_s};
      if (capReg) {regAddr, dataHi} <= shiftReg;
      // A second data byte in one transaction is refused.
      if (evIf.start)  dataDone <= 1'b0;
      else if (commit) dataDone <= 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      RD_DATA   <= '0;
      WR_STROBE <= 1'b0;
      WR_ADDR   <= '0;
      WR_DATA   <= '0;
      TXN_CNT   <= '0;
    end else begin
      WR_STROBE <= commit;
      RD_DATA   <= regs[RD_ADDR];
      if (commit) begin
        WR_ADDR <= regAddr;
        WR_DATA <= commitData;
        TXN_CNT <= TXN_CNT + 8'd1;
`ifdef I2C_SLAVE_RESET_REG_EN
        if (regAddr == SOFT_RST_ADDR && commitData == '0) begin
          for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (regAddr[6:4] == 3'b000) begin
          regs[regAddr[3:0]] <= commitData;
        end
`else
        if (regAddr[6:4] == 3'b000) regs[regAddr[3:0]] <= commitData;
`endif
      end
    end
  end

endmodule

// File: tb/tb_i2c_codec_slave.sv
// Directed and randomized I2C writes against a register-file model of the slave.
module tb_i2c_codec_slave;

  localparam int         Q      = 2;
  localparam logic [7:0] ADDR_W = {7'h1A, 1'b0};

  logic       CLOCK_50 = 1'b0;
  logic       iRST_N;
  logic       sclDrv;
  logic       sdaDrvLow;
  wire        sdaBus;
  logic [3:0] rdAddr;
  logic [8:0] RD_DATA;
  logic       WR_STROBE;
  logic [6:0] WR_ADDR;
  logic [8:0] WR_DATA;
  logic       ACTIVE;
  logic [7:0] TXN_CNT;

  pullup (sdaBus);
  assign sdaBus = sdaDrvLow ? 1'b0 : 1'bz;

  always #10 CLOCK_50 = ~CLOCK_50;

  i2c_codec_slave #(.SLAVE_ADDR(7'h1A)) dut (
    .CLOCK_50  (CLOCK_50),
    .iRST_N    (iRST_N),
    .I2C_SCLK  (sclDrv),
    .I2C_SDAT  (sdaBus),
    .RD_ADDR   (rdAddr),
    .RD_DATA   (RD_DATA),
    .WR_STROBE (WR_STROBE),
    .WR_ADDR   (WR_ADDR),
    .WR_DATA   (WR_DATA),
    .ACTIVE    (ACTIVE),
    .TXN_CNT   (TXN_CNT)
  );

  int         nCmp = 0;
  int         nFail = 0;
  int         strobeCnt = 0;
  logic [8:0] mdl [16];
  int         mdlTxn;
  logic [6:0] expWrAddr;
  logic [8:0] expWrData;

  always @(negedge CLOCK_50) if (WR_STROBE === 1'b1) strobeCnt++;

  task automatic waitClk(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic sdaLevel();
    return (sdaBus === 1'b0) ? 1'b0 : 1'b1;
  endfunction

  // Reference behaviour of one committed write.
  function automatic void modelCommit(input logic [7:0] b1, input logic [7:0] b2);
    logic [6:0] a;
    logic [8:0] d;
    a = b1[7:1];
    d = {b1[0], b2};
    expWrAddr = a;
    expWrData = d;
    mdlTxn = (mdlTxn + 1) % 256;
`ifdef I2C_SLAVE_RESET_REG_EN
    if (a == 7'h0F && d == 9'h000) begin
      for (int i = 0; i < 16; i++) mdl[i] = 9'h000;
      return;
    end
`endif
    if (a < 7'd16) mdl[a[3:0]] = d;
  endfunction

  task automatic i2cStart();
    sdaDrvLow = 1'b0; waitClk(Q);
    sclDrv = 1'b1;    waitClk(Q);
    sdaDrvLow = 1'b1; waitClk(Q);
    sclDrv = 1'b0;    waitClk(Q);
  endtask

  task automatic i2cStop();
    sdaDrvLow = 1'b1; waitClk(Q);
    sclDrv = 1'b1;    waitClk(Q);
    sdaDrvLow = 1'b0; waitClk(Q + 2);
  endtask

  task automatic sendBits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sdaDrvLow = ~b[i]; waitClk(Q);
      sclDrv = 1'b1;     waitClk(Q);
      sclDrv = 1'b0;     waitClk(Q);
    end
  endtask

  task automatic ackBit(output logic acked);
    sdaDrvLow = 1'b0; waitClk(Q);
    sclDrv = 1'b1;    waitClk(1);
    acked = (sdaBus === 1'b0);
    waitClk(Q - 1);
    sclDrv = 1'b0;    waitClk(Q);
  endtask

  task automatic doTxn(input logic [7:0] a, b1, b2, output logic [2:0] acks);
    logic k;
    i2cStart();
    sendBits(a);  ackBit(k); acks[2] = k;
    sendBits(b1); ackBit(k); acks[1] = k;
    sendBits(b2); ackBit(k); acks[0] = k;
    i2cStop();
  endtask

  task automatic checkWrite(input string tag, input logic [7:0] a, b1, b2, input bit full);
    logic [2:0] acks;
    int         s0;
    bit         addrOk;
    s0 = strobeCnt;
    addrOk = (a == ADDR_W);
    doTxn(a, b1, b2, acks);
    if (addrOk) modelCommit(b1, b2);
    chk({tag, "_acks"}, 32'(acks), addrOk ? 32'h7 : 32'h0);
    if (full) begin
      chk({tag, "_strobes"}, 32'(strobeCnt - s0), addrOk ? 32'd1 : 32'd0);
      chk({tag, "_txn"}, 32'(TXN_CNT), 32'(mdlTxn));
      if (addrOk) begin
        chk({tag, "_wraddr"}, 32'(WR_ADDR), 32'(expWrAddr));
        chk({tag, "_wrdata"}, 32'(WR_DATA), 32'(expWrData));
      end
    end
  endtask

  task automatic checkRegs(input string tag);
    for (int i = 0; i < 16; i++) begin
      rdAddr = 4'(i);
      waitClk(1);
      chk($sformatf("%s_reg%0d", tag, i), 32'(RD_DATA), 32'(mdl[i]));
    end
    chk({tag, "_active"}, 32'(ACTIVE), 32'(mdl[9][0]));
  endtask

  task automatic randWrite(input string tag, input bit full, input bit goodAddr);
    logic [7:0] a, b1, b2;
    a  = goodAddr ? ADDR_W : 8'($urandom);
    b1 = {7'($urandom_range(0, 23)), 1'($urandom_range(0, 1))};
    b2 = 8'($urandom);
    checkWrite(tag, a, b1, b2, full);
  endtask

  initial begin : main
    logic [6:0] acks7;
    logic       k;
    int         s0;

    iRST_N = 1'b0; sclDrv = 1'b1; sdaDrvLow = 1'b0; rdAddr = 4'd0;
    for (int i = 0; i < 16; i++) mdl[i] = 9'h000;
    mdlTxn = 0; expWrAddr = '0; expWrData = '0;
    waitClk(3);
    chk("rst_strobe", 32'(WR_STROBE), 32'h0);
    chk("rst_wraddr", 32'(WR_ADDR), 32'h0);
    chk("rst_wrdata", 32'(WR_DATA), 32'h0);
    chk("rst_rddata", 32'(RD_DATA), 32'h0);
    chk("rst_active", 32'(ACTIVE), 32'h0);
    chk("rst_txn", 32'(TXN_CNT), 32'h0);
    chk("rst_sda", 32'(sdaLevel()), 32'h1);
    iRST_N = 1'b1;
    waitClk(5);
    checkRegs("init");

    checkWrite("basic", 8'h34, 8'h0E, 8'h4D, 1'b1);
    rdAddr = 4'd7; waitClk(1);
    chk("basic_reg7", 32'(RD_DATA), 32'h04D);
    chk("basic_txn1", 32'(TXN_CNT), 32'd1);

    checkWrite("active", 8'h34, 8'h12, 8'h01, 1'b1);
    chk("active_out", 32'(ACTIVE), 32'h1);

    checkWrite("badaddr", 8'h40, 8'h0E, 8'h55, 1'b1);
    checkWrite("readbit", 8'h35, 8'h0E, 8'h55, 1'b1);
    checkRegs("nack");

    // Transfer cut by STOP, then one interrupted by a repeated START.
    s0 = strobeCnt;
    i2cStart();
    sendBits(8'h34); ackBit(k); acks7[6] = k;
    sendBits(8'h0E); ackBit(k); acks7[5] = k;
    i2cStop();
    chk("partial_strobes", 32'(strobeCnt - s0), 32'd0);
    chk("partial_txn", 32'(TXN_CNT), 32'(mdlTxn));
    i2cStart();
    sendBits(8'h34); ackBit(k); acks7[4] = k;
    sendBits(8'h0E); ackBit(k); acks7[3] = k;
    i2cStart();
    sendBits(8'h34); ackBit(k); acks7[2] = k;
    sendBits(8'h0E); ackBit(k); acks7[1] = k;
    sendBits(8'h4D); ackBit(k); acks7[0] = k;
    i2cStop();
    modelCommit(8'h0E, 8'h4D);
    chk("restart_acks", 32'(acks7), 32'h7F);
    chk("restart_strobes", 32'(strobeCnt - s0), 32'd1);
    chk("restart_txn", 32'(TXN_CNT), 32'(mdlTxn));

    // Third data byte is refused; the first commit stands.
    s0 = strobeCnt;
    i2cStart();
    sendBits(8'h34); ackBit(k); acks7[3] = k;
    sendBits(8'h06); ackBit(k); acks7[2] = k;
    sendBits(8'h11); ackBit(k); acks7[1] = k;
    sendBits(8'h22); ackBit(k); acks7[0] = k;
    i2cStop();
    modelCommit(8'h06, 8'h11);
    chk("third_acks", 32'(acks7[3:0]), 32'hE);
    chk("third_strobes", 32'(strobeCnt - s0), 32'd1);
    chk("third_wrdata", 32'(WR_DATA), 32'h011);

    checkWrite("highreg", 8'h34, 8'h41, 8'h99, 1'b1);
    checkRegs("highreg");

    for (int i = 0; i < 12; i++) randWrite($sformatf("rand%0d", i), 1'b1, $urandom_range(0, 3) != 0);
    checkRegs("rand");

    for (int i = 0; i < 16; i++)
      checkWrite($sformatf("load%0d", i), 8'h34, {3'b000, 4'(i), 1'b1}, 8'($urandom_range(1, 255)), 1'b0);
    checkRegs("loaded");
    checkWrite("softrst", 8'h34, 8'h1E, 8'h00, 1'b1);
    checkRegs("softrst");

    // Reset while the data-byte ACK is being driven.
    i2cStart();
    sendBits(8'h34); ackBit(k);
    sendBits(8'h0A); ackBit(k);
    sendBits(8'h77);
    waitClk(4);
    chk("datarst_ackdrv", 32'(sdaLevel()), 32'h0);
    iRST_N = 1'b0;
    #1;
    chk("datarst_sda", 32'(sdaLevel()), 32'h1);
    chk("datarst_txn", 32'(TXN_CNT), 32'h0);
    for (int i = 0; i < 16; i++) mdl[i] = 9'h000;
    mdlTxn = 0;
    waitClk(2);
    iRST_N = 1'b1;
    s0 = strobeCnt;
    ackBit(k);        acks7[1] = k;
    sendBits(8'h5A);
    ackBit(k);        acks7[0] = k;
    i2cStop();
    chk("postrst_acks", 32'(acks7[1:0]), 32'h0);
    chk("postrst_strobes", 32'(strobeCnt - s0), 32'd0);
    checkRegs("postrst");

    s0 = strobeCnt;
    for (int i = 0; i < 255; i++) randWrite($sformatf("wrap%0d", i), 1'b0, 1'b1);
    chk("wrap_txn255", 32'(TXN_CNT), 32'd255);
    randWrite("wrap_last", 1'b0, 1'b1);
    chk("wrap_txn0", 32'(TXN_CNT), 32'd0);
    chk("wrap_strobes", 32'(strobeCnt - s0), 32'd256);
    checkRegs("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule

// File: doc/i2c_codec_slave.md
I2C_CODEC_SLAVE -- requirements
Module: i2c_codec_slave

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h1A, meaning the 7-bit I2C target address (write address byte 0x34).
REQ-002 SHALL have port CLOCK_50  input  1  system clock.
REQ-003 SHALL have port iRST_N  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port I2C_SCLK  input  1  I2C clock from the initiator.
REQ-005 SHALL have port I2C_SDAT  inout  1  I2C data; open-drain, driven 0 or high-Z only.
REQ-006 SHALL have port RD_ADDR  input  4  register file read index.
REQ-007 SHALL have port RD_DATA  output  9  registered contents of register RD_ADDR.
REQ-008 SHALL have port WR_STROBE  output  1  one-cycle pulse on each committed register write.
REQ-009 SHALL have port WR_ADDR  output  7  register address of the last committed write.
REQ-010 SHALL have port WR_DATA  output  9  data of the last committed write.
REQ-011 SHALL have port ACTIVE  output  1  equal to bit 0 of register 9.
REQ-012 SHALL have port TXN_CNT  output  8  count of committed writes.

Function
REQ-013 SHALL pass SCL and SDA through 2-flop synchronizers, then detect edges on the synchronized values.
REQ-014 SHALL detect START when SDA falls while SCL is high, and STOP when SDA rises while SCL is high.
REQ-015 SHALL sample SDA on each SCL rising edge, MSB first, and drive or release SDA only on SCL falling edges.
REQ-016 SHALL implement states IDLE, ADDR, ACK_ADDR, REG, ACK_REG, DATA, ACK_DATA and IGNORE.
REQ-017 SHALL enter ADDR and clear the bit counter on START from any state, so repeated START is supported.
REQ-018 SHALL go to IDLE and release SDA on STOP from any state, discarding any partial transfer with no strobe.
REQ-019 SHALL, in ADDR after 8 bits, ACK if the address equals SLAVE_ADDR with R/W=0; otherwise (mismatch or read) it SHALL NACK (leave SDA released) and enter IGNORE until START or STOP.
REQ-020 SHALL, in REG, capture byte1 as {reg_addr[6:0], data[8]}, ACK it, then enter DATA.
REQ-021 SHALL, in DATA, capture byte2 as data[7:0] and ACK it.
REQ-022 SHALL drive ACK low from the SCL falling edge after bit 8 until the next SCL falling edge.
REQ-023 SHALL commit a write in the CLOCK_50 cycle in which the data-byte ACK is first driven.
REQ-024 SHALL, at commit: pulse WR_STROBE for 1 cycle; update WR_ADDR and WR_DATA; write register reg_addr[3:0] if reg_addr < 16; increment TXN_CNT, wrapping 255 -> 0.
REQ-025 SHALL, for reg_addr >= 16, ACK and strobe but leave the register file unchanged.
REQ-026 SHALL NACK a third or later data byte in the same transaction and enter IGNORE; the earlier commit stands.
REQ-027 SHALL update RD_DATA one cycle after a RD_ADDR change; a committed write SHALL be visible on RD_DATA on the next cycle.

Reset
REQ-028 SHALL, on iRST_N low, asynchronously: set state to IDLE, release SDA, clear all 16 registers to 9'h000, and zero WR_STROBE, WR_ADDR, WR_DATA, RD_DATA, ACTIVE and TXN_CNT.
REQ-029 SHALL, when reset is released mid-transaction, ignore bus traffic until the next START.

Configuration
REQ-030 SHALL, with I2C_SLAVE_RESET_REG_EN defined, treat a commit to reg_addr 7'h0F with data 9'h000 as a soft reset: all registers clear to 0 in the commit cycle, and the strobe and TXN_CNT still update.
REQ-031 SHALL, without I2C_SLAVE_RESET_REG_EN, treat register 15 as an ordinary storage register.

Structure
REQ-032 SHALL place the state enum, register count (16), register width (9) and the soft-reset address 7'h0F in shared package i2c_codec_pkg.
REQ-033 SHALL place START/STOP detection and the synchronizers in sub-module i2c_bus_sync, with outputs scl_rise, scl_fall, sda_s, start and stop.

Verification
REQ-034 SHALL verify: bytes 0x34,0x0E,0x4D then STOP -> three ACKs, register 7 = 9'h04D, WR_STROBE pulses once, TXN_CNT = 1.
REQ-035 SHALL verify: bytes 0x34,0x12,0x01 -> register 9 = 9'h001 and ACTIVE = 1.
REQ-036 SHALL verify: address byte 0x40, and separately 0x35 -> NACK, no strobe, registers unchanged.
REQ-037 SHALL verify: 0x34,0x0E then STOP -> no commit; a repeated START followed by 0x34,0x0E,0x4D -> commit.
REQ-038 SHALL verify, with the macro: registers loaded, then 0x34,0x1E,0x00 -> all registers read 0; without the macro, register 15 = 9'h000 and the others are unchanged.
REQ-039 SHALL verify: 256 commits -> TXN_CNT wraps to 0; reset asserted during DATA -> SDA released immediately and TXN_CNT = 0.
